// File: rtl/program_loader_if.sv
// Purpose: bundles the loader's controller enables, UART RX/TX and program-memory write port.
// Latency: none; this is a plain signal bundle.
// Backpressure: TX uses valid/ready; RX bytes arrive as single-cycle pulses with no backpressure.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  transmit_0x99;
  logic                  program_data_size_wren;
  logic                  program_memory_wren;
  logic                  transmit_0xAA;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  tx_ready;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic [31:0]           program_data_size;
  logic                  pmem_we;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [31:0]           pmem_wdata;
  logic                  program_data_size_fetch_finished;
  logic                  program_data_fetch_finished;

  // Loader side
  modport slave (
    input  transmit_0x99, program_data_size_wren, program_memory_wren, transmit_0xAA,
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, program_data_size, pmem_we, pmem_addr, pmem_wdata,
    output program_data_size_fetch_finished, program_data_fetch_finished
  );

  // Controller / UART / memory side
  modport master (
    output transmit_0x99, program_data_size_wren, program_memory_wren, transmit_0xAA,
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, program_data_size, pmem_we, pmem_addr, pmem_wdata,
    input  program_data_size_fetch_finished, program_data_fetch_finished
  );
endinterface

// File: rtl/program_loader.sv
// Purpose: boot download responder: sends 0x99, takes a 4-byte size, packs program bytes into words, sends 0xAA.
// Latency: TX valid and memory writes are registered, one cycle after the triggering sample.
// Backpressure: TX byte is held until tx_ready; RX bytes cannot be stalled and are dropped when not accepted.
module program_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_99,
    S_RECV_SIZE,
    S_LOAD,
    S_WAIT_AA,
    S_SEND_AA,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;
  logic [31:0]           r_size;
  logic [2:0]            r_size_cnt;
  logic                  r_size_done;
  logic [31:0]           r_byte_cnt;
  logic [1:0]            r_lane;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic                  r_pmem_we;
  logic [ADDR_WIDTH-1:0] r_pmem_addr;
  logic [31:0]           r_pmem_wdata;
  logic                  r_load_done;

  logic                  w_tx_hs;
  logic                  w_start_tx;
  logic                  w_size_full;
  logic                  w_size_acc;
  logic                  w_load_acc;
  logic                  w_zero_size;
  logic [31:0]           w_cnt_nxt;
  logic                  w_last;
  logic                  w_flush;
  logic [31:0]           w_word_nxt;

  assign w_tx_hs     = r_tx_valid && bus.tx_ready;
  assign w_start_tx  = ((r_state == S_IDLE) && bus.transmit_0x99) ||
                       ((r_state == S_WAIT_AA) && bus.transmit_0xAA);
  // Counter bit 2 marks all four size bytes taken; the state moves on one cycle later,
  // so a byte arriving right after the 4th size byte is still seen by RECV_SIZE and dropped.
  assign w_size_full = r_size_cnt[2];
  assign w_size_acc  = (r_state == S_RECV_SIZE) && bus.rx_valid &&
                       bus.program_data_size_wren && !w_size_full;
  assign w_zero_size = (r_state == S_LOAD) && (r_size == 32'd0);
  assign w_load_acc  = (r_state == S_LOAD) && bus.rx_valid &&
                       bus.program_memory_wren && (r_size != 32'd0);
  assign w_cnt_nxt   = r_byte_cnt + 32'd1;
  assign w_last      = (w_cnt_nxt == r_size);
  assign w_flush     = w_load_acc && ((r_lane == 2'd3) || w_last);
  // Lanes fill in order from a cleared word, so unfilled upper lanes stay zero.
  assign w_word_nxt  = r_word | ({24'd0, bus.rx_data} << {r_lane, 3'b000});

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (bus.transmit_0x99) w_state_nxt = S_SEND_99;
      S_SEND_99:   if (w_tx_hs)           w_state_nxt = S_RECV_SIZE;
      S_RECV_SIZE: if (w_size_full)       w_state_nxt = S_LOAD;
      S_LOAD:      if (w_zero_size || (w_load_acc && w_last)) w_state_nxt = S_WAIT_AA;
      S_WAIT_AA:   if (bus.transmit_0xAA) w_state_nxt = S_SEND_AA;
      S_SEND_AA:   if (w_tx_hs)           w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_DONE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // TX byte offer: raised on request, held until accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_start_tx) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= (r_state == S_IDLE) ? 8'h99 : 8'hAA;
    end else if (w_tx_hs) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Size assembly, little-endian, with sticky completion flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_size      <= 32'd0;
      r_size_cnt  <= 3'd0;
      r_size_done <= 1'b0;
    end else if (w_size_acc) begin
      r_size[{r_size_cnt[1:0], 3'b000} +: 8] <= bus.rx_data;
      r_size_cnt <= r_size_cnt + 3'd1;
      if (r_size_cnt == 3'd3) r_size_done <= 1'b1;
    end
  end

  // Program byte packing and one-cycle memory write strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_byte_cnt   <= 32'd0;
      r_lane       <= 2'd0;
      r_word       <= 32'd0;
      r_word_idx   <= '0;
      r_pmem_we    <= 1'b0;
      r_pmem_addr  <= '0;
      r_pmem_wdata <= 32'd0;
      r_load_done  <= 1'b0;
    end else begin
      r_pmem_we <= 1'b0;
      if (w_load_acc) begin
        r_byte_cnt <= w_cnt_nxt;
        if (w_flush) begin
          r_pmem_we    <= 1'b1;
          r_pmem_addr  <= r_word_idx;
          r_pmem_wdata <= w_word_nxt;
          r_word       <= 32'd0;
          r_lane       <= 2'd0;
          r_word_idx   <= r_word_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          r_word <= w_word_nxt;
          r_lane <= r_lane + 2'd1;
        end
        if (w_last) r_load_done <= 1'b1;
      end
      if (w_zero_size) r_load_done <= 1'b1;
    end
  end

  assign bus.tx_valid                         = r_tx_valid;
  assign bus.tx_data                          = r_tx_data;
  assign bus.program_data_size                = r_size;
  assign bus.pmem_we                          = r_pmem_we;
  assign bus.pmem_addr                        = r_pmem_addr;
  assign bus.pmem_wdata                       = r_pmem_wdata;
  assign bus.program_data_size_fetch_finished = r_size_done;
  assign bus.program_data_fetch_finished      = r_load_done;

endmodule

// File: doc/program_loader.md
# program_loader

Responder side of the boot-time program download handshake. Driven by the core state controller's loader enables (`transmit_0x99`, `program_data_size_wren`, `program_memory_wren`, `transmit_0xAA`), it does four things in order:
- sends the 0x99 ready byte over UART TX;
- receives a 4-byte program size;
- streams the program bytes into instruction memory as 32-bit words;
- sends the 0xAA completion byte.

It reports progress back to the controller through `program_data_size_fetch_finished` and `program_data_fetch_finished`.

## Interface
- `ADDR_WIDTH`, default 15: program memory word-address width.
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `transmit_0x99` in 1: controller level request to send the ready byte.
- `program_data_size_wren` in 1: controller enable for accepting size bytes.
- `program_memory_wren` in 1: controller enable for accepting program bytes.
- `transmit_0xAA` in 1: controller level request to send the done byte.
- `rx_valid` in 1: one-cycle pulse; `rx_data` holds a received byte.
- `rx_data` in 8: received UART byte.
- `tx_ready` in 1: UART TX can accept a byte this cycle.
- `tx_valid` out 1: byte offered to UART TX.
- `tx_data` out 8: byte offered to UART TX.
- `program_data_size` out 32: program length in bytes, little-endian assembled.
- `pmem_we` out 1: program memory write strobe, one cycle per word.
- `pmem_addr` out ADDR_WIDTH: word address of the write.
- `pmem_wdata` out 32: word data of the write.
- `program_data_size_fetch_finished` out 1: size received; sticky until reset.
- `program_data_fetch_finished` out 1: all program bytes written; sticky until reset.

## Operation
- **States:** IDLE → SEND_99 → RECV_SIZE → LOAD → WAIT_AA → SEND_AA → DONE. DONE holds until reset.
- **IDLE:** when `transmit_0x99` = 1, go to SEND_99.
- **SEND_99:** drive `tx_valid` = 1, `tx_data` = 0x99. On `tx_valid && tx_ready`, go to RECV_SIZE. Exactly one byte is sent even if `transmit_0x99` stays high.
- **RECV_SIZE:**
  - A byte is accepted only when `rx_valid && program_data_size_wren`.
  - Size byte i (0..3) lands in `program_data_size[8i+7:8i]`.
  - After byte 3: set `program_data_size_fetch_finished`, go to LOAD.
- **LOAD:**
  - A byte is accepted only when `rx_valid && program_memory_wren`.
  - A 32-bit byte counter and a 2-bit lane index are maintained. Byte k goes into word lane k mod 4 (little-endian).
  - When lane 3 fills, or the final byte (counter reaches `program_data_size`) arrives, issue one `pmem_we` pulse. Unfilled lanes of a final partial word are zero.
  - `pmem_addr` = word index starting at 0, wrapping modulo 2^ADDR_WIDTH.
  - After the final write, set `program_data_fetch_finished` and go to WAIT_AA.
  - If `program_data_size` = 0: no writes; set `program_data_fetch_finished` on the first LOAD cycle.
- **WAIT_AA:** when `transmit_0xAA` = 1, go to SEND_AA.
- **SEND_AA:** behaves like SEND_99 but with `tx_data` = 0xAA; on acceptance go to DONE.
- **Dropped bytes:** bytes are silently discarded when the enable is low or the state is IDLE, SEND_99, WAIT_AA, SEND_AA or DONE. Nothing is buffered.
- **Reset mid-operation:** any state returns to IDLE. Counters, size and flags clear; partially assembled words are discarded.

## Timing
- **Reset values:** `tx_valid` 0, `tx_data` 0x00, `program_data_size` 0, `pmem_we` 0, `pmem_addr` 0, `pmem_wdata` 0, both finished flags 0.
- **TX outputs:** registered. `tx_valid` rises the cycle after the request is sampled in IDLE or WAIT_AA, and falls the cycle after the `tx_ready` handshake.
- **Size:** `program_data_size_fetch_finished` rises the cycle after the 4th size byte is accepted. `program_data_size` is valid in that same cycle.
- **Memory write:** `pmem_we`, `pmem_addr` and `pmem_wdata` are registered and asserted the cycle after the completing byte. `pmem_we` is high for exactly one cycle.
- **Load complete:** `program_data_fetch_finished` rises in the same cycle as the final `pmem_we`.
- **Throughput:** back-to-back `rx_valid` every cycle is supported.
- **Overlapping events:** an `rx_valid` arriving in the cycle a state is entered is handled by the state registered in that cycle. Example: the byte sampled in the same cycle the 4th size byte completes is dropped, because the state is still RECV_SIZE with a full counter.

## Test plan
- **Ready byte:** hold `transmit_0x99` = 1, `tx_ready` = 0 for 5 cycles, then 1 → `tx_valid` held with 0x99, exactly one handshake, `tx_valid` 0 afterwards.
- **Full-word load:** size bytes 08,00,00,00, then program bytes 01..08, enables high → size = 8; writes (addr 0, 0x04030201) and (addr 1, 0x08070605); `program_data_fetch_finished` with the 2nd write.
- **Partial word:** size 5, bytes AA,BB,CC,DD,EE → writes 0xDDCCBBAA @0 and 0x000000EE @1.
- **Zero size and done byte:** size 0 → no `pmem_we`; `program_data_fetch_finished` the cycle after entering LOAD; `transmit_0xAA` then yields one 0xAA byte, state DONE.
- **Gated bytes:** bytes with `program_memory_wren` = 0 interleaved with the stream → they are ignored; write data matches only the enabled bytes.
- **Reset mid-load:** assert `reset_n` = 0 after 6 of 8 bytes → all outputs at reset values next cycle; a full restart loads correctly from addr 0.
